// File: rtl/data_dec_pkg.sv
// Shared sizes and the capture/drain state encoding
// used by the data path blocks.
package data_dec_pkg;

  localparam int DD_N = 5;
  localparam int DD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/dec_lane.sv
// One result lane: row write counter, write enable
// and overflow detect.
module dec_lane
  import data_dec_pkg::*;
#(
  parameter int N  = DD_N,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_vld,
  output logic [CW-1:0] o_wc,
  output logic          o_we,
  output logic          o_full,
  output logic          o_ovf
);

  logic [CW-1:0] r_wc;

  assign o_wc   = r_wc;
  assign o_full = (r_wc == CW'(N));
  assign o_we   = i_vld & i_en & ~o_full;
  assign o_ovf  = i_vld & (~i_en | o_full);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wc <= '0;
    end else if (o_we) begin
      r_wc <= r_wc + 1'b1;
    end
  end

endmodule

// File: rtl/data_dec.sv
// Collects skewed column lanes into an NxN buffer,
// then streams it out row-major over valid/ready.
module data_dec
  import data_dec_pkg::*;
#(
  parameter int N = DD_N,
  parameter int W = DD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_a,
  input  logic [W-1:0] d_b,
  input  logic [W-1:0] d_c,
  input  logic [W-1:0] d_d,
  input  logic [W-1:0] d_e,
  input  logic [N-1:0] d_vld,
  output logic [W-1:0] out_data,
  output logic [2:0]   out_row,
  output logic [2:0]   out_col,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         done,
  output logic         err
);

  localparam int NN = N * N;
  localparam int RW = $clog2(NN);
  localparam int CW = $clog2(N + 1);

  state_t        r_state;
  logic [RW-1:0] r_rd;
  logic [2:0]    r_row;
  logic [2:0]    r_col;
  logic          r_valid;
  logic          r_done;
  logic          r_err;
  logic [W-1:0]  r_buf [NN];

  logic [W-1:0]  w_lane [5];
  logic [CW-1:0] w_wc [N];
  logic [RW-1:0] w_waddr [N];
  logic [N-1:0]  w_we;
  logic [N-1:0]  w_full;
  logic [N-1:0]  w_ovf;
  logic          w_en;
  logic          w_clr;
  logic          w_hs;
  logic          w_at_last;

  assign w_lane[0] = d_a;
  assign w_lane[1] = d_b;
  assign w_lane[2] = d_c;
  assign w_lane[3] = d_d;
  assign w_lane[4] = d_e;

  // Writes are accepted only while capturing.
  assign w_en  = (r_state == IDLE) ||
                 (r_state == FILL);
  assign w_clr = (r_state == DONE);

  for (genvar i = 0; i < N; i++) begin : g_lane
    dec_lane #(
      .N  (N),
      .CW (CW)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_en   (w_en),
      .i_vld  (d_vld[i]),
      .o_wc   (w_wc[i]),
      .o_we   (w_we[i]),
      .o_full (w_full[i]),
      .o_ovf  (w_ovf[i])
    );

    assign w_waddr[i] =
      RW'(int'(w_wc[i]) * N + i);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (w_we[i]) begin
        r_buf[w_waddr[i]] <= w_lane[i];
      end
    end
  end

  assign w_hs      = r_valid & out_ready;
  assign w_at_last = (r_rd == RW'(NN - 1));

  assign out_valid = r_valid;
  assign out_last  = r_valid & w_at_last;
  assign out_data  = r_valid ? r_buf[r_rd] : '0;
  assign out_row   = r_valid ? r_row : '0;
  assign out_col   = r_valid ? r_col : '0;
  assign done      = r_done;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rd    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (|w_ovf) begin
        r_err <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (|d_vld) begin
            r_state <= FILL;
          end
        end
        FILL: begin
          if (&w_full) begin
            r_state <= DRAIN;
            r_valid <= 1'b1;
            r_rd    <= '0;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        DRAIN: begin
          if (w_hs) begin
            if (w_at_last) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_rd <= r_rd + 1'b1;
              if (r_col == 3'(N - 1)) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_rd    <= '0;
          r_row   <= '0;
          r_col   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
